// File: rtl/array_kxk_pkg.sv
// array_kxk_pkg: shared constants, sync bundle type and helpers for the KxK window builder.
// Latency: n/a (types, constants and functions only).
// Backpressure: n/a.
package array_kxk_pkg;

    // Border handling modes for taps that fall outside the frame.
    localparam int unsigned BORDER_ZERO = 0;
    localparam int unsigned BORDER_REPL = 1;

    // Video sync sideband carried alongside the pixel pipeline.
    typedef struct packed {
        logic vs;
        logic de;
    } sync_t;

    // Bit offset of window tap (r,c) inside the flat KxK window bus.
    function automatic int unsigned win_idx(input int unsigned r, input int unsigned c,
                                            input int unsigned k, input int unsigned dsize);
        return (r * k + c) * dsize;
    endfunction

    // Only odd window sizes 3, 5 and 7 are supported.
    function automatic bit k_legal(input int unsigned k);
        return (k == 3) || (k == 5) || (k == 7);
    endfunction

endpackage

// File: rtl/line_buffer_ram.sv
// line_buffer_ram: simple dual-port line store, one write and one read port.
// Latency: 1 cycle read; a read and write to the same address return the old data.
// Backpressure: none, both ports are serviced every cycle.
//
// Ports:
//   clock            pixel clock
//   wr_vld/addr/dat  write port
//   rd_addr, rd_dat  read port, rd_dat registered (contents are not reset)
module line_buffer_ram #(
    parameter  int unsigned DSIZE = 16,
    parameter  int unsigned DEPTH = 1920,
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clock,
    input  logic             wr_vld,
    input  logic [AW-1:0]    wr_addr,
    input  logic [DSIZE-1:0] wr_dat,
    input  logic [AW-1:0]    rd_addr,
    output logic [DSIZE-1:0] rd_dat
);

    logic [DSIZE-1:0] mem [DEPTH];
    logic [DSIZE-1:0] rd_dat_q;

    // Non-blocking read of mem gives read-before-write at a shared address.
    always_ff @(posedge clock) begin
        rd_dat_q <= mem[rd_addr];
        if (wr_vld) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat = rd_dat_q;

endmodule

// File: rtl/array_kxk.sv
// array_kxk: builds a KxK pixel window from a raster stream using K-1 line buffers.
// Latency: fixed 2 cycles from indata to tap (0,0); outvs/outde delayed to match.
// Backpressure: none, one pixel is accepted on every inde cycle.
//
// Ports:
//   clock, rst          pixel clock, asynchronous active-high reset
//   invs, inde, indata  input raster stream (vsync, data enable, pixel)
//   outvs, outde        sync outputs aligned with outwin
//   outwin              K*K taps, tap (r,c) = pixel (y-r, x-c) at [(r*K+c)*DSIZE +: DSIZE]
//   line_err            sticky: some line carried more than VIDEO_WIDTH pixels
module array_kxk
    import array_kxk_pkg::*;
#(
    parameter int unsigned DSIZE       = 16,
    parameter int unsigned K           = 3,
    parameter int unsigned VIDEO_WIDTH = 1920,
    parameter int unsigned BORDER      = 0
) (
    input  logic                   clock,
    input  logic                   rst,
    input  logic                   invs,
    input  logic                   inde,
    input  logic [DSIZE-1:0]       indata,
    output logic                   outvs,
    output logic                   outde,
    output logic [K*K*DSIZE-1:0]   outwin,
    output logic                   line_err
);

    localparam int unsigned XW = (VIDEO_WIDTH > 1) ? $clog2(VIDEO_WIDTH) : 1;
    localparam int unsigned YW = $clog2(K);
    localparam logic [XW-1:0] X_LAST = XW'(VIDEO_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(K - 1);

    if (!k_legal(K)) begin : g_bad_k
        $error("array_kxk: K must be 3, 5 or 7");
    end
    if ((BORDER != BORDER_ZERO) && (BORDER != BORDER_REPL)) begin : g_bad_border
        $error("array_kxk: BORDER must be 0 or 1");
    end

    // Front end: column/row counters and overflow tracking.
    logic [XW-1:0]        x_q, x_d;
    logic                 full_q, full_d;
    logic [YW-1:0]        y_q, y_d;
    logic                 err_q, err_d;
    // Stage 1: registered pixel, sync and position; RAM reads are in flight.
    sync_t                sync1_q, sync1_d;
    logic [XW-1:0]        x1_q, x1_d;
    logic [YW-1:0]        y1_q, y1_d;
    logic                 wr1_q, wr1_d;
    logic [DSIZE-1:0]     dat1_q, dat1_d;
    // Stage 2: window column registers and aligned sync.
    sync_t                sync2_q, sync2_d;
    logic [K*K*DSIZE-1:0] win_q, win_d;

    logic vs_rise, de_fall, wr0;

    logic [DSIZE-1:0] rd_dat [K-1];
    logic [DSIZE-1:0] raw    [K];
    logic [DSIZE-1:0] vert   [K];

    always_comb begin
        vs_rise = invs && !sync1_q.vs;
        de_fall = !inde && sync1_q.de;
        // full_q marks that the last legal column was already taken this line;
        // any further pixel is an overflow and must not disturb the buffers.
        wr0     = inde && !full_q;

        x_d    = x_q;
        full_d = full_q;
        y_d    = y_q;
        err_d  = err_q;

        if (!inde) begin
            x_d    = '0;
            full_d = 1'b0;
        end else if (!full_q) begin
            if (x_q == X_LAST) begin
                full_d = 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end

        // A frame start overrides a coincident end-of-line increment.
        if (vs_rise) begin
            y_d = '0;
        end else if (de_fall && (y_q != Y_LAST)) begin
            y_d = y_q + 1'b1;
        end

        if (inde && full_q) begin
            err_d = 1'b1;
        end

        sync1_d.vs = invs;
        sync1_d.de = inde;
        x1_d       = x_q;
        y1_d       = y_q;
        wr1_d      = wr0;
        dat1_d     = indata;
        sync2_d    = sync1_q;
    end

    // LB0 captures the live line; each further buffer is fed one cycle later
    // from its predecessor's read data, so LBi holds the line i+1 rows up.
    for (genvar i = 0; i < K - 1; i++) begin : g_lb
        logic             wr_vld;
        logic [XW-1:0]    wr_addr;
        logic [DSIZE-1:0] wr_dat;
        if (i == 0) begin : g_head
            assign wr_vld  = wr0;
            assign wr_addr = x_q;
            assign wr_dat  = indata;
        end else begin : g_chain
            assign wr_vld  = wr1_q;
            assign wr_addr = x1_q;
            assign wr_dat  = rd_dat[i-1];
        end
        line_buffer_ram #(
            .DSIZE (DSIZE),
            .DEPTH (VIDEO_WIDTH)
        ) u_ram (
            .clock   (clock),
            .wr_vld  (wr_vld),
            .wr_addr (wr_addr),
            .wr_dat  (wr_dat),
            .rd_addr (x_q),
            .rd_dat  (rd_dat[i])
        );
    end

    always_comb begin
        raw[0] = dat1_q;
        for (int r = 1; r < K; r++) begin
            raw[r] = rd_dat[r-1];
        end
    end

    // Rows above the frame top are either zero or a copy of the topmost
    // in-frame row; y1_q is saturated so this only bites on early lines.
    always_comb begin
        for (int r = 0; r < K; r++) begin
            vert[r] = '0;
            if (YW'(r) <= y1_q) begin
                vert[r] = raw[r];
            end else if (BORDER == BORDER_REPL) begin
                vert[r] = raw[y1_q];
            end
        end
    end

    // On the first pixel of a line the older columns are preloaded, which
    // gives the left border; otherwise each row shifts by one column.
    always_comb begin
        win_d = win_q;
        if (sync1_q.de) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    if (c == 0) begin
                        win_d[win_idx(r, c, K, DSIZE) +: DSIZE] = vert[r];
                    end else if (x1_q == '0) begin
                        win_d[win_idx(r, c, K, DSIZE) +: DSIZE] =
                            (BORDER == BORDER_REPL) ? vert[r] : '0;
                    end else begin
                        win_d[win_idx(r, c, K, DSIZE) +: DSIZE] =
                            win_q[win_idx(r, c - 1, K, DSIZE) +: DSIZE];
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            x_q     <= '0;
            full_q  <= 1'b0;
            y_q     <= '0;
            err_q   <= 1'b0;
            sync1_q <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            wr1_q   <= 1'b0;
            dat1_q  <= '0;
            sync2_q <= '0;
            win_q   <= '0;
        end else begin
            x_q     <= x_d;
            full_q  <= full_d;
            y_q     <= y_d;
            err_q   <= err_d;
            sync1_q <= sync1_d;
            x1_q    <= x1_d;
            y1_q    <= y1_d;
            wr1_q   <= wr1_d;
            dat1_q  <= dat1_d;
            sync2_q <= sync2_d;
            win_q   <= win_d;
        end
    end

    assign outvs    = sync2_q.vs;
    assign outde    = sync2_q.de;
    assign outwin   = win_q;
    assign line_err = err_q;

endmodule

// File: tb/tb_array_kxk.sv
// tb_array_kxk: checks three array_kxk instances (K3 zero, K3 replicate, K5 zero) on one stream.
// Latency: expected outputs are the model's view of the sample two edges earlier.
// Backpressure: none; stimulus is a fixed directed raster sequence.
module tb_array_kxk;

    localparam int DW   = 16;
    localparam int VW   = 8;
    localparam int WMAX = 25 * DW;
    localparam int KK [3] = '{3, 3, 5};
    localparam int BB [3] = '{0, 1, 0};

    logic          clock  = 1'b0;
    logic          rst    = 1'b1;
    logic          invs   = 1'b0;
    logic          inde   = 1'b0;
    logic [DW-1:0] indata = '0;

    logic [9*DW-1:0]  win0, win1;
    logic [25*DW-1:0] win2;
    logic [2:0]       dut_vs, dut_de, dut_err;
    logic [WMAX-1:0]  dut_win [3];

    always #5 clock = ~clock;

    array_kxk #(.DSIZE(DW), .K(3), .VIDEO_WIDTH(VW), .BORDER(0)) u_k3z (
        .clock(clock), .rst(rst), .invs(invs), .inde(inde), .indata(indata),
        .outvs(dut_vs[0]), .outde(dut_de[0]), .outwin(win0), .line_err(dut_err[0]));
    array_kxk #(.DSIZE(DW), .K(3), .VIDEO_WIDTH(VW), .BORDER(1)) u_k3r (
        .clock(clock), .rst(rst), .invs(invs), .inde(inde), .indata(indata),
        .outvs(dut_vs[1]), .outde(dut_de[1]), .outwin(win1), .line_err(dut_err[1]));
    array_kxk #(.DSIZE(DW), .K(5), .VIDEO_WIDTH(VW), .BORDER(0)) u_k5z (
        .clock(clock), .rst(rst), .invs(invs), .inde(inde), .indata(indata),
        .outvs(dut_vs[2]), .outde(dut_de[2]), .outwin(win2), .line_err(dut_err[2]));

    assign dut_win[0] = WMAX'(win0);
    assign dut_win[1] = WMAX'(win1);
    assign dut_win[2] = win2;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [WMAX-1:0] act, input logic [WMAX-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DW-1:0] fpix [16][16];
    int  row = 0, xcnt = 0, fid = 0;
    bit  vs_p = 0, de_p = 0, fvalid = 0, err_m = 0;
    bit  cur_vs = 0, cur_de = 0, cur_chk = 0, prev_vs = 0, prev_de = 0, prev_chk = 0;
    int  cur_row = 0, cur_col = 0, cur_fid = 0, prev_row = 0, prev_col = 0, prev_fid = 0;
    logic [WMAX-1:0] cur_win [3];
    logic [WMAX-1:0] prev_win [3];

    // Window straight from the definition: tap(r,c) = pixel(row-r, col-c),
    // out-of-frame coordinates either zero or clamped to 0.
    function automatic logic [WMAX-1:0] exp_win(input int k, input int b, input int prow, input int pcol);
        logic [WMAX-1:0] w;
        w = '0;
        for (int r = 0; r < k; r++) begin
            for (int c = 0; c < k; c++) begin
                int rr;
                int cc;
                rr = prow - r;
                cc = pcol - c;
                if (b == 1) begin
                    if (rr < 0) rr = 0;
                    if (cc < 0) cc = 0;
                end
                if (rr >= 0 && cc >= 0) w[(r*k+c)*DW +: DW] = fpix[rr][cc];
            end
        end
        return w;
    endfunction

    function automatic logic [DW-1:0] tap(input logic [WMAX-1:0] w, input int r, input int c, input int k);
        return w[(r*k+c)*DW +: DW];
    endfunction

    initial begin
        for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) fpix[r][c] = '0;
        for (int i = 0; i < 3; i++) begin cur_win[i] = '0; prev_win[i] = '0; end
    end

    always @(posedge clock) begin
        prev_vs = cur_vs; prev_de = cur_de; prev_chk = cur_chk;
        prev_row = cur_row; prev_col = cur_col; prev_fid = cur_fid;
        for (int i = 0; i < 3; i++) prev_win[i] = cur_win[i];
        if (rst) begin
            row = 0; xcnt = 0; vs_p = 0; de_p = 0; fvalid = 0; err_m = 0;
            cur_vs = 0; cur_de = 0; cur_chk = 0;
            prev_vs = 0; prev_de = 0; prev_chk = 0;
        end else begin
            cur_vs = invs; cur_de = inde; cur_chk = 0;
            if (invs && !vs_p) begin
                row = 0; fvalid = 1; fid++;
            end else if (!inde && de_p) begin
                row++;
            end
            if (inde) begin
                if (xcnt < VW) begin
                    if (row < 16) fpix[row][xcnt] = indata;
                    if (fvalid && row < 16) begin
                        cur_chk = 1; cur_row = row; cur_col = xcnt; cur_fid = fid;
                        for (int i = 0; i < 3; i++) cur_win[i] = exp_win(KK[i], BB[i], row, xcnt);
                    end
                end else begin
                    err_m = 1;
                end
                xcnt++;
            end else begin
                xcnt = 0;
            end
            vs_p = invs; de_p = inde;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clock) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                chk("rst_outde", WMAX'(dut_de[i]), '0);
                chk("rst_outvs", WMAX'(dut_vs[i]), '0);
                chk("rst_line_err", WMAX'(dut_err[i]), '0);
                chk("rst_outwin", dut_win[i], '0);
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                chk("outde_delay2", WMAX'(dut_de[i]), WMAX'(prev_de));
                chk("outvs_delay2", WMAX'(dut_vs[i]), WMAX'(prev_vs));
                chk("line_err", WMAX'(dut_err[i]), WMAX'(err_m));
                if (prev_de && prev_chk) chk("outwin_model", dut_win[i], prev_win[i]);
            end
            if (prev_chk && prev_fid == 1 && prev_row == 2 && prev_col == 5)
                chk("k3z_tap00_l2x5", WMAX'(tap(dut_win[0], 0, 0, 3)), WMAX'(16'h0205));
            if (prev_chk && prev_fid == 1 && prev_row == 0 && prev_col == 0)
                chk("k3z_all_zero_l0x0", dut_win[0], '0);
            if (prev_chk && prev_fid == 1 && prev_row == 1 && prev_col == 1) begin
                chk("k3z_tap11_l1x1", WMAX'(tap(dut_win[0], 1, 1, 3)), WMAX'(16'h0000));
                chk("k3z_tap10_l1x1", WMAX'(tap(dut_win[0], 1, 0, 3)), WMAX'(16'h0001));
                for (int c = 0; c < 3; c++)
                    chk("k3z_tap2c_l1x1", WMAX'(tap(dut_win[0], 2, c, 3)), WMAX'(16'h0000));
            end
            if (prev_chk && prev_fid == 1 && prev_row == 1 && prev_col == 0) begin
                chk("k3r_tap02_l1x0", WMAX'(tap(dut_win[1], 0, 2, 3)), WMAX'(16'h0100));
                chk("k3r_tap01_l1x0", WMAX'(tap(dut_win[1], 0, 1, 3)), WMAX'(16'h0100));
                chk("k3r_tap20_l1x0", WMAX'(tap(dut_win[1], 2, 0, 3)), WMAX'(16'h0000));
            end
            if (prev_chk && prev_fid == 1 && prev_row == 3 && prev_col == 4)
                chk("k3r_tap22_l3x4", WMAX'(tap(dut_win[1], 2, 2, 3)), WMAX'(16'h0102));
            if (prev_chk && prev_fid == 2 && prev_row == 5 && prev_col == 7) begin
                for (int r = 0; r < 5; r++) begin
                    for (int c = 0; c < 5; c++) begin
                        logic [7:0] ry;
                        logic [7:0] cx;
                        ry = 8'(5 - r);
                        cx = 8'(7 - c);
                        chk("k5z_tap_l5x7", WMAX'(tap(dut_win[2], r, c, 5)), WMAX'({ry, cx}));
                    end
                end
            end
            if (prev_chk && prev_fid == 4 && prev_row == 2 && prev_col == 7)
                chk("line_err_sticky", WMAX'(dut_err[0]), WMAX'(1'b1));
            if (prev_chk && prev_fid == 6 && prev_row == 0 && prev_col == 2) begin
                chk("restart_k3z_tap10", WMAX'(tap(dut_win[0], 1, 0, 3)), WMAX'(16'h0000));
                chk("restart_k3r_tap10", WMAX'(tap(dut_win[1], 1, 0, 3)), WMAX'(16'h0002));
                chk("restart_k3r_tap12", WMAX'(tap(dut_win[1], 1, 2, 3)), WMAX'(16'h0000));
            end
            if (prev_chk && prev_fid == 8 && prev_row == 0 && prev_col == 0)
                chk("line_err_after_rst", WMAX'(dut_err[0]), WMAX'(1'b0));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit vs, input bit de, input logic [DW-1:0] d);
        @(posedge clock);
        #2;
        invs   = vs;
        inde   = de;
        indata = d;
    endtask

    task automatic send_line(input int tag, input int n);
        for (int x = 0; x < n; x++) step(1'b0, 1'b1, {tag[7:0], x[7:0]});
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
    endtask

    task automatic vsync_pulse();
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        step(1'b0, 1'b0, '0);
    endtask

    task automatic send_frame(input int nlines, input int n);
        vsync_pulse();
        for (int l = 0; l < nlines; l++) send_line(l, n);
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #2 rst = 1'b0;
        repeat (3) step(1'b0, 1'b0, '0);

        send_frame(4, 8);            // frame 1: latency, zero and replicate borders
        send_frame(6, 8);            // frame 2: K=5 full window
        send_frame(1, 10);           // frame 3: overflowing line
        send_frame(3, 8);            // frame 4: normal frame after overflow

        vsync_pulse();               // frame 5: two lines, then restart mid-frame
        send_line(8'h30, 8);
        send_line(8'h31, 8);
        send_frame(2, 8);            // frame 6: top border must reappear

        vsync_pulse();               // frame 7: reset in the middle of line 1
        send_line(0, 8);
        for (int x = 0; x < 4; x++) step(1'b0, 1'b1, {8'h01, x[7:0]});
        @(posedge clock);
        #2;
        rst  = 1'b1;
        inde = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("async_rst_outde", WMAX'(dut_de[i]), '0);
            chk("async_rst_outwin", dut_win[i], '0);
        end
        repeat (3) @(posedge clock);
        #2 rst = 1'b0;
        repeat (2) step(1'b0, 1'b0, '0);

        send_frame(3, 8);            // frame 8: clean frame after reset
        repeat (5) step(1'b0, 1'b0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/array_kxk.md
Name: array_kxk

Overview:
- Parametrised successor to the 3x3 video tap: builds a KxK pixel window from a raster stream (vsync/de/data) using K-1 RAM line buffers plus per-row column shift registers.
- Adds runtime-safe border handling (zero or replicate) for the top rows and left columns, a fixed 2-cycle latency with aligned sync outputs, and a sticky line-overflow flag.
- Sits between the video sync generator / pixel source and 2-D filter kernels (median, sobel, convolution).

Parameters:
- DSIZE, 16, pixel width in bits.
- K, 3, window size; legal values 3, 5, 7 (odd only).
- VIDEO_WIDTH, 1920, maximum active pixels per line; sets line-buffer depth.
- BORDER, 0, 0 = zero-fill out-of-frame taps; 1 = replicate nearest in-frame pixel.

Ports:
- clock  in  1  pixel clock.
- rst  in  1  asynchronous active-high reset.
- invs  in  1  vertical sync, active high; rising edge = frame start.
- inde  in  1  data enable, active high during active pixels.
- indata  in  DSIZE  pixel.
- outvs  out  1  invs delayed 2 cycles.
- outde  out  1  inde delayed 2 cycles.
- outwin  out  K*K*DSIZE  window; tap (r,c) at [(r*K+c)*DSIZE +: DSIZE] = pixel (y-r, x-c); tap (0,0) = current pixel.
- line_err  out  1  sticky: a line exceeded VIDEO_WIDTH pixels.

Behaviour:
- Interface: one clock, `clock`; reset `rst` is asynchronous and active-high.
- Reset: outvs=0, outde=0, outwin=0, line_err=0; column counter x=0, row counter y=0. Line-buffer RAM contents are not reset.
- Column counter x: increments on each inde cycle; cleared on the cycle after inde falls.
- Row counter y: increments on each inde falling edge; saturates at K-1; cleared on invs rising edge.
- Line buffers: K-1 simple dual-port RAMs, depth VIDEO_WIDTH, 1-cycle read latency, read-before-write at the same address.
  - LB0 is written with indata at address x.
  - LBi (i ≥ 1) is written with the LB(i-1) read data at address x.
- Pipeline: stage 1 issues the RAM read at x and registers indata. Stage 2 shifts each row's K-stage column register and drives outwin. Latency from indata to tap (0,0) is 2 cycles; outde and outvs use matching 2-stage delays.
- Row border: when r > y (row above frame top):
  - BORDER=0: the tap reads 0.
  - BORDER=1: the tap reads the row-(y) value, i.e. the topmost in-frame row at that column.
- Column border: when c > x (column left of line start):
  - BORDER=0: the tap reads 0.
  - BORDER=1: the tap reads column 0 of the same row, i.e. column registers are preloaded with the first pixel at x=0.
- Row and column borders combine: a corner tap gets BORDER=0 → 0, BORDER=1 → pixel (topmost valid row, col 0).
- outwin is held when outde=0; window contents are not guaranteed meaningful while outde=0.
- Overflow: when x reaches VIDEO_WIDTH while inde is still high, writes for that line are suppressed, x saturates, and line_err sets. line_err clears only on rst.
- Simultaneous events:
  - invs rising in the same cycle as inde falling: the clear wins, y=0.
  - inde high during invs: processed normally.
- Reset mid-line: outputs drop to reset values immediately. The next frame is correct once the next invs rising edge arrives; y restarts at 0, so stale RAM data is masked by the border logic.

Decomposition:
- Package array_kxk_pkg: function win_idx(r,c,K) returning the bit offset; BORDER_ZERO / BORDER_REPL constants; elaboration check that K is odd and in 3..7.
- Sub-module line_buffer_ram (DSIZE, DEPTH): one simple dual-port RAM, 1-cycle read, read-before-write; instantiated K-1 times with a generate loop.

Test Plan:
- Reset and latency: K=3, DSIZE=16, VIDEO_WIDTH=8, BORDER=0, data={y,x}. A 4-line frame → outde is inde delayed exactly 2 cycles; tap(0,0) at line 2, x=5 equals 0x0205.
- Zero border: same config, line 0, x=0 → all taps 0 except tap(0,0)=0x0000. Line 1, x=1 → tap(1,1)=0x0000, tap(1,0)=0x0001, tap(2,*)=0.
- Replicate border: BORDER=1, line 1, x=0 → tap(0,2)=tap(0,1)=0x0100. tap(2,0)=0x0000 (row 0 replicated). Line 3, x=4 → tap(2,2)=0x0102.
- Generalised size: K=5, frame of 6 lines × 8 pixels. At line 5, x=7: tap(r,c)={5-r,7-c} for all r,c in 0..4.
- Overflow: VIDEO_WIDTH=8, drive one 10-pixel line → line_err=1 and stays 1 across frames. The next normal frame's windows match the model, and x never exceeds 7.
- Frame restart and async reset: assert invs mid-stream → y=0 and the next line shows top-border taps. Assert rst mid-line → outde=0 and outwin=0 the same cycle; the next frame is correct.
